// File: rtl/ahb3lite_gpio_pkg.sv
// Shared constants and types for the AHB3-Lite GPIO slave: register word indices,
// AHB encodings, response FSM state type and the transfer-error decode.
package ahb3lite_gpio_pkg;

    // Register word indices (byte offset >> 2)
    localparam logic [2:0] RegDataOut     = 3'd0;  // 0x00
    localparam logic [2:0] RegSet         = 3'd1;  // 0x04
    localparam logic [2:0] RegClr         = 3'd2;  // 0x08
    localparam logic [2:0] RegTgl         = 3'd3;  // 0x0C
    localparam logic [2:0] RegDataIn      = 3'd4;  // 0x10
    localparam logic [2:0] RegBlinkPeriod = 3'd5;  // 0x14
    localparam logic [2:0] RegBlinkMask   = 3'd6;  // 0x18

    localparam logic [1:0] HTransIdle   = 2'b00;
    localparam logic [1:0] HTransBusy   = 2'b01;
    localparam logic [1:0] HTransNonseq = 2'b10;
    localparam logic [1:0] HTransSeq    = 2'b11;

    localparam logic [2:0] HSizeByte = 3'b000;
    localparam logic [2:0] HSizeHalf = 3'b001;
    localparam logic [2:0] HSizeWord = 3'b010;

    localparam int unsigned BlinkWidth = 24;

    typedef enum logic [1:0] {StOkay, StErr1, StErr2} rsp_state_e;

    function automatic logic xfer_error(input logic [2:0] idx, input logic wr,
                                        input logic [2:0] size);
        return (idx > RegBlinkMask) || (wr && (idx == RegDataIn)) ||
               (wr && (size != HSizeWord));
    endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchronizer for asynchronous GPIO inputs, synchronous active-low reset.
module gpio_sync2 #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ahb3lite_gpio_slave.sv
// AHB3-Lite GPIO slave: output register with set/clear/toggle aliases and synchronized inputs.
// Define AHB3LITE_GPIO_BLINK_EN to build the blink counter (BLINK_PERIOD / BLINK_MASK).
module ahb3lite_gpio_slave
    import ahb3lite_gpio_pkg::*;
#(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned G_NUM_GPIO = 8
) (
    input  logic                  hclk_i,
    input  logic                  hreset_n_i,
    input  logic                  hsel_i,
    input  logic [HADDR_SIZE-1:0] haddr_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [3:0]            hprot_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hready_i,
    input  logic [HDATA_SIZE-1:0] hwdata_i,
    output logic [HDATA_SIZE-1:0] hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic [G_NUM_GPIO-1:0] gpio_o,
    input  logic [G_NUM_GPIO-1:0] gpio_i
);

    logic                  addr_valid_q;
    logic [2:0]            addr_idx_q;
    logic                  addr_write_q;
    logic [2:0]            addr_size_q;
    rsp_state_e            state_q, state_d;
    logic [G_NUM_GPIO-1:0] data_out_q, data_out_d;
    logic [G_NUM_GPIO-1:0] data_in;
    logic [G_NUM_GPIO-1:0] wdata_gpio;
    logic [G_NUM_GPIO-1:0] toggle_mask;
    logic [BlinkWidth-1:0] period_rd;
    logic [G_NUM_GPIO-1:0] mask_rd;
    logic [HDATA_SIZE-1:0] rdata;
    logic                  accept;
    logic                  accept_err;
    logic                  dp_err;
    logic                  wr_en;
    logic                  rd_en;
    logic                  unused_ok;

    assign unused_ok = ^{hburst_i, hprot_i, haddr_i, hwdata_i};

    assign accept     = hsel_i & hready_i & htrans_i[1];
    assign accept_err = accept & xfer_error(haddr_i[4:2], hwrite_i, hsize_i);

    // Address phase is only re-sampled when the bus advances; ERR1 holds it.
    always_ff @(posedge hclk_i) begin
        if (!hreset_n_i) begin
            addr_valid_q <= 1'b0;
            addr_idx_q   <= '0;
            addr_write_q <= 1'b0;
            addr_size_q  <= '0;
        end else if (hready_i) begin
            addr_valid_q <= accept;
            addr_idx_q   <= haddr_i[4:2];
            addr_write_q <= hwrite_i;
            addr_size_q  <= hsize_i;
        end
    end

    assign dp_err     = xfer_error(addr_idx_q, addr_write_q, addr_size_q);
    assign wr_en      = addr_valid_q & addr_write_q & ~dp_err & hready_i;
    assign rd_en      = addr_valid_q & ~addr_write_q & ~dp_err;
    assign wdata_gpio = hwdata_i[G_NUM_GPIO-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOkay:  if (accept_err) state_d = StErr1;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = accept_err ? StErr1 : StOkay;
            default: state_d = StOkay;
        endcase
    end

    always_ff @(posedge hclk_i) begin
        if (!hreset_n_i) begin
            state_q <= StOkay;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef AHB3LITE_GPIO_BLINK_EN
    logic [BlinkWidth-1:0] period_q, period_d;
    logic [BlinkWidth-1:0] cnt_q, cnt_d;
    logic [G_NUM_GPIO-1:0] mask_q, mask_d;
    logic                  toggle;

    always_comb begin
        period_d = period_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        toggle   = 1'b0;
        if (period_q != '0) begin
            if (cnt_q == '0) begin
                cnt_d  = period_q;
                toggle = 1'b1;
            end else begin
                cnt_d = cnt_q - BlinkWidth'(1);
            end
        end
        if (wr_en && (addr_idx_q == RegBlinkPeriod)) begin
            period_d = hwdata_i[BlinkWidth-1:0];
            cnt_d    = hwdata_i[BlinkWidth-1:0];
        end
        if (wr_en && (addr_idx_q == RegBlinkMask)) begin
            mask_d = wdata_gpio;
        end
    end

    always_ff @(posedge hclk_i) begin
        if (!hreset_n_i) begin
            period_q <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
        end
    end

    assign toggle_mask = toggle ? mask_q : '0;
    assign period_rd   = period_q;
    assign mask_rd     = mask_q;
`else
    assign toggle_mask = '0;
    assign period_rd   = '0;
    assign mask_rd     = '0;
`endif

    // A bus write to the output register wins over a coincident blink toggle.
    always_comb begin
        data_out_d = data_out_q ^ toggle_mask;
        if (wr_en) begin
            case (addr_idx_q)
                RegDataOut: data_out_d = wdata_gpio;
                RegSet:     data_out_d = data_out_q | wdata_gpio;
                RegClr:     data_out_d = data_out_q & ~wdata_gpio;
                RegTgl:     data_out_d = data_out_q ^ wdata_gpio;
                default:    data_out_d = data_out_q ^ toggle_mask;
            endcase
        end
    end

    always_ff @(posedge hclk_i) begin
        if (!hreset_n_i) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    gpio_sync2 #(
        .Width (G_NUM_GPIO)
    ) u_sync (
        .clk_i  (hclk_i),
        .rst_ni (hreset_n_i),
        .d_i    (gpio_i),
        .q_o    (data_in)
    );

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr_idx_q)
                RegDataOut, RegSet, RegClr, RegTgl: rdata[G_NUM_GPIO-1:0] = data_out_q;
                RegDataIn:      rdata[G_NUM_GPIO-1:0] = data_in;
                RegBlinkPeriod: rdata[BlinkWidth-1:0] = period_rd;
                RegBlinkMask:   rdata[G_NUM_GPIO-1:0] = mask_rd;
                default:        rdata = '0;
            endcase
        end
    end

    assign hrdata_o    = hreset_n_i ? rdata : '0;
    assign hreadyout_o = ~hreset_n_i | (state_q != StErr1);
    assign hresp_o     = hreset_n_i & (state_q != StOkay);
    assign gpio_o      = data_out_q;

endmodule
